// File: rtl/score_controller.sv
// Pong game-flow sequencer: owns both score counters, sequences
// IDLE -> SERVE_WAIT -> PLAY -> (SERVE_WAIT | GAME_OVER), and gates the ball.
// All outputs are registered; timing inside SERVE_WAIT is counted in frame ticks.
module score_controller #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [3:0] counter_left,
    output logic [3:0] counter_right,
    output logic       ball_enable,
    output logic       serve,
    output logic       serve_dir,
    output logic       game_over
);

    localparam int unsigned DW = $clog2(SERVE_DELAY + 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_SERVE_WAIT = 2'd1;
    localparam logic [1:0] S_PLAY       = 2'd2;
    localparam logic [1:0] S_GAME_OVER  = 2'd3;

    logic [1:0]    r_state;
    logic          r_btn_q;
    logic [DW-1:0] r_delay;
    logic [3:0]    r_left;
    logic [3:0]    r_right;
    logic          r_ball;
    logic          r_serve;
    logic          r_dir;
    logic          r_go;

    logic [1:0]    w_state_nxt;
    logic [DW-1:0] w_delay_nxt;
    logic [3:0]    w_left_nxt;
    logic [3:0]    w_right_nxt;
    logic          w_serve_nxt;
    logic          w_dir_nxt;
    logic          w_ball_nxt;
    logic          w_go_nxt;
    logic          w_start_rise;
    logic [3:0]    w_left_inc;
    logic [3:0]    w_right_inc;

    assign w_start_rise = start_btn & ~r_btn_q;
    assign w_left_inc   = r_left + 4'd1;
    assign w_right_inc  = r_right + 4'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, score, delay and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_delay_nxt = r_delay;
        w_left_nxt  = r_left;
        w_right_nxt = r_right;
        w_dir_nxt   = r_dir;
        w_serve_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt = S_SERVE_WAIT;
                    w_left_nxt  = 4'd0;
                    w_right_nxt = 4'd0;
                    w_dir_nxt   = 1'b0;
                    w_delay_nxt = '0;
                end
            end
            S_SERVE_WAIT: begin
                if (frame_tick) begin
                    if (r_delay == DELAY_LAST) begin
                        w_state_nxt = S_PLAY;
                        w_serve_nxt = 1'b1;
                    end else begin
                        w_delay_nxt = r_delay + DW'(1);
                    end
                end
            end
            S_PLAY: begin
                // A coincident frame_tick is dropped: delay restarts from zero.
                if (miss_left && miss_right) begin
                    w_state_nxt = S_SERVE_WAIT;
                    w_delay_nxt = '0;
                end else if (miss_right) begin
                    w_left_nxt  = w_left_inc;
                    w_dir_nxt   = 1'b1;
                    w_delay_nxt = '0;
                    w_state_nxt = (w_left_inc == WIN) ? S_GAME_OVER : S_SERVE_WAIT;
                end else if (miss_left) begin
                    w_right_nxt = w_right_inc;
                    w_dir_nxt   = 1'b0;
                    w_delay_nxt = '0;
                    w_state_nxt = (w_right_inc == WIN) ? S_GAME_OVER : S_SERVE_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_ball_nxt = (w_state_nxt == S_PLAY);
        w_go_nxt   = (w_state_nxt == S_GAME_OVER);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_q <= 1'b0;
            r_delay <= '0;
            r_left  <= 4'd0;
            r_right <= 4'd0;
            r_ball  <= 1'b0;
            r_serve <= 1'b0;
            r_dir   <= 1'b0;
            r_go    <= 1'b0;
        end else begin
            r_btn_q <= start_btn;
            r_delay <= w_delay_nxt;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_ball  <= w_ball_nxt;
            r_serve <= w_serve_nxt;
            r_dir   <= w_dir_nxt;
            r_go    <= w_go_nxt;
        end
    end

    assign counter_left  = r_left;
    assign counter_right = r_right;
    assign ball_enable   = r_ball;
    assign serve         = r_serve;
    assign serve_dir     = r_dir;
    assign game_over     = r_go;

endmodule

// File: tb/tb_score_controller.sv
// Self-checking bench for score_controller with SERVE_DELAY=4, WIN_SCORE=3.
module tb_score_controller;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic [3:0] counter_left;
    logic [3:0] counter_right;
    logic       ball_enable;
    logic       serve;
    logic       serve_dir;
    logic       game_over;

    score_controller #(.WIN_SCORE(3), .SERVE_DELAY(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .miss_left    (miss_left),
        .miss_right   (miss_right),
        .counter_left (counter_left),
        .counter_right(counter_right),
        .ball_enable  (ball_enable),
        .serve        (serve),
        .serve_dir    (serve_dir),
        .game_over    (game_over)
    );

    // inputs + expected outputs after the clock edge that samples them
    typedef struct packed {
        logic       ft;
        logic       sb;
        logic       ml;
        logic       mr;
        logic [3:0] el;
        logic [3:0] er;
        logic       be;
        logic       sv;
        logic       sd;
        logic       go;
    } vec_t;

    typedef struct {
        int          id;
        logic [11:0] exp;
    } sb_t;

    sb_t        sbq[$];
    sb_t        mon_e;
    vec_t       vecs[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         vid     = 0;
    logic [11:0] obs;

    assign obs = {counter_left, counter_right, ball_enable, serve, serve_dir, game_over};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Scoreboard checker: one expected word per driven cycle
    always @(posedge clk) begin
        #1;
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            n_tests++;
            if (obs !== mon_e.exp) begin
                n_fail++;
                $display("FAIL step %0d: got L=%0d R=%0d be=%b sv=%b dir=%b go=%b, required L=%0d R=%0d be=%b sv=%b dir=%b go=%b",
                         mon_e.id, obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
                         mon_e.exp[11:8], mon_e.exp[7:4], mon_e.exp[3], mon_e.exp[2],
                         mon_e.exp[1], mon_e.exp[0]);
            end
        end
    end

    function automatic vec_t mk(input logic ft, sb, ml, mr, input logic [3:0] el, er,
                                input logic be, sv, sd, go);
        vec_t v;
        v.ft = ft; v.sb = sb; v.ml = ml; v.mr = mr;
        v.el = el; v.er = er; v.be = be; v.sv = sv; v.sd = sd; v.go = go;
        return v;
    endfunction

    task automatic cyc(input logic ft, sb, ml, mr, input logic [3:0] el, er,
                       input logic be, sv, sd, go);
        sb_t e;
        @(negedge clk);
        frame_tick = ft;
        start_btn  = sb;
        miss_left  = ml;
        miss_right = mr;
        e.id  = vid;
        e.exp = {el, er, be, sv, sd, go};
        sbq.push_back(e);
        vid++;
    endtask

    // Three ticks with no serve, fourth tick serves, then one quiet PLAY cycle
    task automatic serve_seq(input logic sb, input logic [3:0] l, r, input logic d);
        for (int i = 0; i < 3; i++) cyc(1'b1, sb, 1'b0, 1'b0, l, r, 1'b0, 1'b0, d, 1'b0);
        cyc(1'b1, sb, 1'b0, 1'b0, l, r, 1'b1, 1'b1, d, 1'b0);
        cyc(1'b0, sb, 1'b0, 1'b0, l, r, 1'b1, 1'b0, d, 1'b0);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;

        // serve timing, scoring, tick-with-miss, double miss, ignored inputs
        vecs.push_back(mk(0,0,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 4'd0,4'd0, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd0,4'd0, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0, 4'd0,4'd0, 1,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd0,4'd0, 1,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4'd0,4'd0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,1, 4'd1,4'd0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd0, 0,0,1,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd0, 1,1,1,0));
        vecs.push_back(mk(0,0,0,0, 4'd1,4'd0, 1,0,1,0));
        vecs.push_back(mk(1,0,1,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,1, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 1,1,0,0));
        vecs.push_back(mk(0,0,1,1, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 4'd1,4'd1, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0, 4'd1,4'd1, 1,0,0,0));

        repeat (2) @(negedge clk);
        chk("reset_state", obs, 12'h000);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].ft, vecs[i].sb, vecs[i].ml, vecs[i].mr, vecs[i].el, vecs[i].er,
                vecs[i].be, vecs[i].sv, vecs[i].sd, vecs[i].go);
        end

        // asynchronous reset in the middle of PLAY
        @(posedge clk);
        #3;
        chk("pre_reset_play", obs, {4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        reset = 1'b1;
        #1;
        chk("async_reset_mid_play", obs, 12'h000);
        @(negedge clk);
        reset = 1'b0;

        // start held through a whole game; left wins 3-0
        cyc(0,1,0,0, 4'd0,4'd0, 0,0,0,0);
        serve_seq(1'b1, 4'd0, 4'd0, 1'b0);
        cyc(0,1,0,1, 4'd1,4'd0, 0,0,1,0);
        serve_seq(1'b1, 4'd1, 4'd0, 1'b1);
        cyc(0,1,0,1, 4'd2,4'd0, 0,0,1,0);
        serve_seq(1'b1, 4'd2, 4'd0, 1'b1);
        cyc(0,1,0,1, 4'd3,4'd0, 0,0,1,1);
        cyc(0,1,1,0, 4'd3,4'd0, 0,0,1,1);
        cyc(1,1,0,1, 4'd3,4'd0, 0,0,1,1);
        cyc(1,1,1,1, 4'd3,4'd0, 0,0,1,1);
        cyc(0,0,0,0, 4'd3,4'd0, 0,0,1,1);
        cyc(0,1,0,0, 4'd0,4'd0, 0,0,0,0);
        serve_seq(1'b0, 4'd0, 4'd0, 1'b0);

        // right wins 3-0 on a miss coinciding with a tick
        cyc(0,0,1,0, 4'd0,4'd1, 0,0,0,0);
        serve_seq(1'b0, 4'd0, 4'd1, 1'b0);
        cyc(0,0,1,0, 4'd0,4'd2, 0,0,0,0);
        serve_seq(1'b0, 4'd0, 4'd2, 1'b0);
        cyc(1,0,1,0, 4'd0,4'd3, 0,0,0,1);
        cyc(1,0,1,0, 4'd0,4'd3, 0,0,0,1);

        @(posedge clk);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries required 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
